// File: rtl/enc32to5_scan.sv
// Multi-hot to binary scanner: accepts a 32-bit register-select vector and
// emits the address of every set bit, lowest first, one per accepted transfer.
module enc32to5_scan (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_adr,
  output logic        out_last,
  output logic        zero_drop,
  output logic        state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid and its payload stay stable until that transfer happens.

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_adr_q, out_adr_d;
  logic        out_last_q, out_last_d;
  logic        zero_drop_q, zero_drop_d;

  function automatic logic [4:0] lsb_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (req != 32'd0) begin
            pending_d = req;
            state_d   = EMIT;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          // Clearing the lowest set bit is exactly the address just emitted.
          pending_d = pending_q & (pending_q - 32'd1);
          if (out_last_q) begin
            state_d   = IDLE;
            pending_d = 32'd0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 32'd0;
      end
    endcase
    out_valid_d = (state_d == EMIT);
    out_adr_d   = out_valid_d ? lsb_index(pending_d) : 5'd0;
    out_last_d  = out_valid_d && ((pending_d & (pending_d - 32'd1)) == 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 32'd0;
      out_valid_q <= 1'b0;
      out_adr_q   <= 5'd0;
      out_last_q  <= 1'b0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_adr_q   <= out_adr_d;
      out_last_q  <= out_last_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  // in_ready is held low while reset is asserted, and rises as soon as it drops.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_adr   = out_adr_q;
  assign out_last  = out_last_q;
  assign zero_drop = zero_drop_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_enc32to5_scan.sv
// Directed bench for enc32to5_scan: a vector table run at full throughput,
// plus hand-written sequences for backpressure, zero vectors and reset.
module tb_enc32to5_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_adr;
  logic        out_last;
  logic        zero_drop;
  logic        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp_q[$];

  typedef struct {
    logic [31:0] req;
    int          exp_count;
    logic [4:0]  first_adr;
    logic [4:0]  last_adr;
  } vec_t;

  vec_t vecs[7];

  enc32to5_scan dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .req(req), .out_valid(out_valid), .out_ready(out_ready),
    .out_adr(out_adr), .out_last(out_last), .zero_drop(zero_drop),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int budget;
    budget = 50;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) check("wait_in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vector(input vec_t v);
    int         n;
    int         budget;
    logic [4:0] exp_adr;
    logic [4:0] first_seen;
    logic [4:0] last_seen;
    exp_q.delete();
    for (int i = 0; i < 32; i++) if (v.req[i]) exp_q.push_back(5'(i));
    wait_in_ready();
    in_valid  = 1'b1;
    req       = v.req;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    req      = $urandom;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    n = 0;
    budget = 40;
    first_seen = 5'd0;
    last_seen  = 5'd0;
    while (out_valid && budget > 0) begin
      if (exp_q.size() == 0) begin
        check("extra_transfer", 32'(out_adr), 32'hFFFF_FFFF);
      end else begin
        exp_adr = exp_q.pop_front();
        check("out_adr", 32'(out_adr), 32'(exp_adr));
        check("out_last", 32'(out_last), 32'(exp_q.size() == 0));
      end
      if (n == 0) first_seen = out_adr;
      last_seen = out_adr;
      n++;
      budget--;
      tick();
    end
    if (budget == 0) check("transfer_timeout", 32'(out_valid), 32'd0);
    check("transfer_count", 32'(n), 32'(v.exp_count));
    check("first_adr", 32'(first_seen), 32'(v.first_adr));
    check("last_adr", 32'(last_seen), 32'(v.last_adr));
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0001,  1,  0,  0};
    vecs[1] = '{32'h8000_0001,  2,  0, 31};
    vecs[2] = '{32'hFFFF_FFFF, 32,  0, 31};
    vecs[3] = '{32'h0000_0014,  2,  2,  4};
    vecs[4] = '{32'h8000_0000,  1, 31, 31};
    vecs[5] = '{32'hA5A5_0000,  8, 16, 31};
    vecs[6] = '{32'h0000_00F0,  4,  4,  7};

    reset = 1'b1; in_valid = 1'b0; req = 32'd0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_adr", 32'(out_adr), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_zero_drop", 32'(zero_drop), 32'd0);
    #9;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);

    for (int k = 0; k < 7; k++) run_vector(vecs[k]);

    // Backpressure on 0x14, with in_valid pulses and req changes during EMIT.
    wait_in_ready();
    in_valid = 1'b1; req = 32'h0000_0014; out_ready = 1'b0;
    tick();
    check("bp_state_emit", 32'(state_dbg), 32'd1);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      in_valid = c[0]; req = $urandom;
      check("bp_held_adr", 32'(out_adr), 32'd2);
      check("bp_held_last", 32'(out_last), 32'd0);
      check("bp_held_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0; req = 32'hFFFF_FFFF; out_ready = 1'b1;
    check("bp_fourth_adr", 32'(out_adr), 32'd2);
    tick();
    check("bp_second_adr", 32'(out_adr), 32'd4);
    check("bp_second_last", 32'(out_last), 32'd1);
    in_valid = 1'b1;
    tick();
    check("bp_no_accept_on_last", 32'(out_valid), 32'd0);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_still_idle", 32'(out_valid), 32'd0);

    // All-zero vector is dropped with a one-cycle pulse.
    check("zd_low_before", 32'(zero_drop), 32'd0);
    in_valid = 1'b1; req = 32'd0;
    tick();
    in_valid = 1'b0;
    check("zd_pulse", 32'(zero_drop), 32'd1);
    check("zd_out_valid", 32'(out_valid), 32'd0);
    check("zd_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("zd_low_after", 32'(zero_drop), 32'd0);
    check("zd_out_valid_after", 32'(out_valid), 32'd0);

    // Reset mid-EMIT after one transfer of 0xF0.
    in_valid = 1'b1; req = 32'h0000_00F0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rm_first_adr", 32'(out_adr), 32'd4);
    tick();
    check("rm_second_adr", 32'(out_adr), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("rm_out_valid_async", 32'(out_valid), 32'd0);
    check("rm_in_ready_async", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rm_in_ready_release", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rm_no_emit", 32'(out_valid), 32'd0);
    end
    check("rm_idle_state", 32'(state_dbg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
